// File: rtl/uart_tx_byte.sv
// 8N1/8N2 UART transmitter with a one-byte hold register, rising-edge byte
// strobe and sticky overrun flag. All outputs are registered.
module uart_tx_byte #(
  parameter int unsigned CYCLES_PER_BIT = 104,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic       vram_clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_in_rdy,
  input  logic       clr_overrun,
  output logic       tx,
  output logic       busy,
  output logic       byte_done,
  output logic       overrun
);

  localparam int unsigned CW = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CYCLES_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_valid_q, hold_valid_d;
  logic          rdy_d_q, rdy_d_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          byte_done_q, byte_done_d;
  logic          overrun_q, overrun_d;

  logic rise, consume, overrun_set, bit_end;

  always_comb begin
    rise         = data_in_rdy & ~rdy_d_q;
    consume      = (state_q == IDLE) & hold_valid_q;
    rdy_d_d      = data_in_rdy;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    overrun_set  = 1'b0;

    if (consume) hold_valid_d = 1'b0;
    // A rise coinciding with consumption refills the hold without overrun.
    if (rise) begin
      if (!hold_valid_q || consume) begin
        hold_d       = data_in;
        hold_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end
    overrun_d = overrun_set ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    bit_end    = (cnt_q == CNT_MAX);
    cnt_d      = bit_end ? '0 : cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hold_valid_q) begin
          shift_d = hold_q;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) state_d = IDLE;
          else                         stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next-state values so the registers line up with the state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d      = (state_d != IDLE) | hold_valid_d;
    byte_done_d = (state_d == STOP) && (cnt_d == CNT_MAX) && (stop_cnt_d == STOP_LAST);
  end

  always_ff @(posedge vram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      rdy_d_q      <= 1'b1;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      byte_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rdy_d_q      <= rdy_d_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      byte_done_q  <= byte_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- Serial UART transmitter at the consuming end of the video-buffer byte stream.
- Accepts bytes presented on data_in with a data_in_rdy level strobe, holds one byte in reserve, and serializes each byte as 8N1 (or 8N2) on tx.
- Runs in the 96 MHz vram_clk domain. Default timing is 921600 baud, which fits one frame inside the 1051-cycle byte slot of the upstream pacer.

Parameters:
CYCLES_PER_BIT, 104, vram_clk cycles per serial bit; legal range 2..4095.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
vram_clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
data_in  input  8  byte to transmit; sampled on a data_in_rdy rising edge.
data_in_rdy  input  1  level strobe; each 0->1 transition offers exactly one byte.
clr_overrun  input  1  synchronous clear for overrun.
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress or the hold register is full.
byte_done  output  1  one-cycle pulse at the end of each frame's last stop bit.
overrun  output  1  sticky flag: a byte was offered while the hold register was full.

Behaviour:
- Reset (asserted asynchronously, released synchronously at the design level):
  - tx=1, busy=0, byte_done=0, overrun=0.
  - FSM=IDLE, hold_valid=0, all counters 0.
  - rdy_d=1, so a data_in_rdy already high at release is not taken as an edge.
- Edge detect:
  - rdy_d is the previous-cycle data_in_rdy; rise = data_in_rdy & ~rdy_d.
  - Let E0 be the first clock edge at which data_in_rdy is sampled high.
- Hold register (8 bits plus hold_valid):
  - On rise with the hold free, data_in is captured at E0 and hold_valid is set.
  - On rise with hold_valid=1 and the hold not being consumed at the same edge, the byte is dropped and overrun is set.
  - Simultaneous rise and FSM consumption of the hold: the new byte is captured and hold_valid stays 1. No overrun is raised.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If hold_valid, copy the hold into the shift register, clear hold_valid, go to START. The hold is always consumed at the edge following its capture, so tx falls at E0+1.
  - START: tx=0 for CYCLES_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. After each CYCLES_PER_BIT cycles, shift right and increment a 3-bit index. After bit 7, go to STOP.
  - STOP: tx=1 for STOP_BITS*CYCLES_PER_BIT cycles. At the final cycle, pulse byte_done for exactly 1 cycle and go to IDLE.
- Frame timing:
  - Frame length = (9+STOP_BITS)*CYCLES_PER_BIT cycles, measured from tx falling to the byte_done cycle inclusive.
  - Back-to-back frames are separated by exactly one extra idle-high cycle (the IDLE visit).
- Counters:
  - Bit-timer width = ceil(log2(CYCLES_PER_BIT)) bits, at most 12. It counts 0..CYCLES_PER_BIT-1 and wraps to 0 on every bit boundary.
  - The stop-bit count is a separate 1-bit counter.
- Output timing:
  - tx is driven from a register (glitch-free).
  - busy = (state != IDLE) | hold_valid, registered with the same timing as the state.
- overrun:
  - Set by an overrun event; cleared by clr_overrun.
  - Set wins when both occur at the same edge.
- data_in changes while data_in_rdy stays high are ignored.
- reset_n asserted mid-frame: tx goes high immediately, the frame is abandoned, and no byte_done pulse is produced.

Test Plan:
- Reset check -> tx=1, busy=0, byte_done=0, overrun=0.
- data_in_rdy held high through reset release -> no frame, tx stays 1.
- Send 0x55 (CYCLES_PER_BIT=104, STOP_BITS=1), single rise at E0 -> tx=0 over E0+1..E0+104, then 1,0,1,0,1,0,1,0 at 104 cycles each, then stop high. byte_done is high only at E0+1040. busy clears the following cycle.
- Send 0x0D then 0x0A, rises 1051 cycles apart -> two correct frames, overrun=0, two byte_done pulses 1051 cycles apart.
- Three rises within 60 cycles (0x41, 0x42, 0x43) -> 0x41 transmitted then 0x42, 0x43 lost, overrun=1 from the third rise. Pulsing clr_overrun then clears it to 0.
- STOP_BITS=2, send 0xFF -> start bit plus 10 high bits, byte_done at E0+1144.
- reset_n low during data bit 3 -> tx=1 asynchronously, no byte_done. After release, a new 0x5A transmits cleanly.
